// File: rtl/minmax_track.sv
// Tracks the largest and smallest unsigned sample over a run of WIN accepted samples.
// Define MINMAX_INDEX_EN to add max_idx/min_idx, the run index of the sample holding each extreme.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; last run's results held on the outputs
// ACC   | accepting samples, din_ready high
// DONE  | single-cycle done pulse, then back to IDLE
module minmax_track #(
  parameter  int SIZE = 4,
  parameter  int WIN  = 8,
  localparam int CW   = $clog2(WIN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [SIZE-1:0] max_out,
  output logic [SIZE-1:0] min_out,
  output logic [CW-1:0]   cnt,
  output logic            busy,
`ifdef MINMAX_INDEX_EN
  output logic            done,
  output logic [CW-1:0]   max_idx,
  output logic [CW-1:0]   min_idx
`else
  output logic            done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] max_q, max_d;
  logic [SIZE-1:0] min_q, min_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            din_ready_q, busy_q, done_q;
  logic            accept;
  logic            first;

  assign accept = (state_q == S_ACC) && din_valid;
  // start clears cnt, so a zero count in ACC marks the run's first sample
  assign first  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          cnt_d   = '0;
        end
      end
      S_ACC: begin
        if (accept) begin
          if (first || (din > max_q)) max_d = din;
          if (first || (din < min_q)) min_d = din;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIN - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      din_ready_q <= (state_d == S_ACC);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_out   = max_q;
  assign min_out   = min_q;
  assign cnt       = cnt_q;

`ifdef MINMAX_INDEX_EN
  logic [CW-1:0] max_idx_q, max_idx_d;
  logic [CW-1:0] min_idx_q, min_idx_d;

  always_comb begin
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    if (accept) begin
      if (first || (din > max_q)) max_idx_d = cnt_q;
      if (first || (din < min_q)) min_idx_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign max_idx = max_idx_q;
  assign min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_minmax_track.sv
// Testbench for minmax_track (SIZE=4, WIN=4): directed and random runs, results checked
// by a done-triggered scoreboard monitor against a reference computed from the sample list.
module tb_minmax_track;
  localparam int SIZE = 4;
  localparam int WIN  = 4;
  localparam int CW   = $clog2(WIN + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [SIZE-1:0] din = '0;
  logic            din_valid = 1'b0;
  logic            din_ready;
  logic [SIZE-1:0] max_out, min_out;
  logic [CW-1:0]   cnt;
  logic            busy, done;
`ifdef MINMAX_INDEX_EN
  logic [CW-1:0]   max_idx, min_idx;
`endif

  minmax_track #(.SIZE(SIZE), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .max_out(max_out), .min_out(min_out), .cnt(cnt),
    .busy(busy),
`ifdef MINMAX_INDEX_EN
    .done(done), .max_idx(max_idx), .min_idx(min_idx)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int mx;
    int mn;
    int mx_i;
    int mn_i;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   prev_max = 0;
  int   prev_min = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: extremes of the list; index is the first position where each extreme occurs.
  function automatic exp_t model(input logic [SIZE-1:0] s[$]);
    exp_t e;
    e.mx = -1; e.mn = 1 << SIZE; e.mx_i = 0; e.mn_i = 0;
    foreach (s[i]) begin
      if (int'(s[i]) > e.mx) begin e.mx = int'(s[i]); e.mx_i = i; end
      if (int'(s[i]) < e.mn) begin e.mn = int'(s[i]); e.mn_i = i; end
    end
    return e;
  endfunction

  // Monitor: every done pulse must correspond to a run the stimulus completed.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("max_out", 32'(max_out), 32'(e.mx));
        chk("min_out", 32'(min_out), 32'(e.mn));
        chk("cnt_at_done", 32'(cnt), 32'(WIN));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("ready_at_done", 32'(din_ready), 32'd0);
`ifdef MINMAX_INDEX_EN
        chk("max_idx", 32'(max_idx), 32'(e.mx_i));
        chk("min_idx", 32'(min_idx), 32'(e.mn_i));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_max"}, 32'(max_out), 32'd0);
    chk({tag, "_min"}, 32'(min_out), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(din_ready), 32'd0);
`ifdef MINMAX_INDEX_EN
    chk({tag, "_max_idx"}, 32'(max_idx), 32'd0);
    chk({tag, "_min_idx"}, 32'(min_idx), 32'd0);
`endif
  endtask

  // One complete run. Caller starts in IDLE (start may already be high).
  task automatic do_run(input logic [SIZE-1:0] s[$], input bit gaps, input bit start_mid,
                        input bit hold_start);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_ready", 32'(din_ready), 32'd1);
    chk("start_clears_cnt", 32'(cnt), 32'd0);
    chk("hold_max", 32'(max_out), 32'(prev_max));
    chk("hold_min", 32'(min_out), 32'(prev_min));
    exp_q.push_back(model(s));
    foreach (s[i]) begin
      if (gaps) begin
        n = $urandom_range(1, 3);
        din_valid = 1'b0;
        din = SIZE'($urandom);
        repeat (n) tick();
        chk("stall_cnt", 32'(cnt), 32'(i));
        chk("stall_ready", 32'(din_ready), 32'd1);
      end
      din = s[i];
      din_valid = 1'b1;
      start = start_mid && (i == 1);
      tick();
      din_valid = 1'b0;
      start = hold_start && (i == s.size() - 1);
      chk("accept_cnt", 32'(cnt), 32'(i + 1));
    end
    // now in DONE; the monitor checks results at the falling edge
    tick();
    chk("back_idle_busy", 32'(busy), 32'd0);
    chk("back_idle_done", 32'(done), 32'd0);
    chk("held_cnt", 32'(cnt), 32'(WIN));
    if (exp_q.size() != 0) begin
      chk("done_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    begin
      exp_t e;
      e = model(s);
      prev_max = e.mx;
      prev_min = e.mn;
    end
  endtask

  initial begin
    logic [SIZE-1:0] s[$];
    #10000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SIZE-1:0] s[$];
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");
    repeat (3) tick();
    chk("idle_no_start_busy", 32'(busy), 32'd0);

    s = '{4'd3, 4'd9, 4'd1, 4'd9};
    do_run(s, 1'b0, 1'b0, 1'b0);
    do_run(s, 1'b1, 1'b0, 1'b0);
    s = '{4'd5, 4'd5, 4'd5, 4'd5};
    do_run(s, 1'b0, 1'b0, 1'b0);
    s = '{4'd0, 4'd15, 4'd15, 4'd0};
    do_run(s, 1'b0, 1'b1, 1'b0);

    // abort after two accepts: with din_valid and start asserted alongside rst
    start = 1'b1;
    tick();
    start = 1'b0;
    din = 4'd7; din_valid = 1'b1;
    tick();
    din = 4'd2;
    tick();
    chk("pre_abort_cnt", 32'(cnt), 32'd2);
    din = 4'd12; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
    check_all_zero("abort");
    repeat (2) tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);
    prev_max = 0;
    prev_min = 0;

    s = '{4'd8, 4'd4, 4'd12, 4'd2};
    do_run(s, 1'b0, 1'b0, 1'b1);
    s = '{4'd1, 4'd14, 4'd6, 4'd14};
    do_run(s, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      s.delete();
      for (int k = 0; k < WIN; k++) s.push_back(SIZE'($urandom_range(0, 15)));
      do_run(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (3) tick();
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
